// File: rtl/axis_arb_pkg.sv
// Shared types and the round-robin selection function for the AXI-Stream packet arbiter.
package axis_arb_pkg;

  localparam int unsigned MAX_PORTS = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Winner is the first requester found searching upward from last+1, wrapping at n.
  function automatic logic [3:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                         input logic [3:0]           last,
                                         input int unsigned          n);
    logic [3:0]  win;
    logic        found;
    int unsigned idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_PORTS; k++) begin
      idx = 32'(last) + k;
      if (idx >= n) idx = idx - n;
      if (!found && (k <= n) && req[idx[3:0]]) begin
        win   = idx[3:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/axis_rr_picker.sv
// Combinational round-robin picker: request vector + last-grant pointer -> winner index.
module axis_rr_picker
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [$clog2(NUM_PORTS)-1:0] ptr,
  output logic [$clog2(NUM_PORTS)-1:0] winner,
  output logic                         any_valid
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);

  logic [MAX_PORTS-1:0] req_ext;
  logic [3:0]           ptr_ext;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_PORTS-1:0] = req;
    ptr_ext                = '0;
    ptr_ext[IDX_W-1:0]     = ptr;
    winner                 = IDX_W'(rr_pick(req_ext, ptr_ext, NUM_PORTS));
    any_valid              = |req;
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_PORTS AXI-Stream slaves into one master.
// Optional m_axis_tid output enabled by defining AXIS_PKT_ARBITER_TID_EN.
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic                            busy
`ifdef AXIS_PKT_ARBITER_TID_EN
  ,
  output logic [$clog2(NUM_PORTS)-1:0]    m_axis_tid
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  axis_rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req      (s_axis_tvalid),
    .ptr      (last_grant_q),
    .winner   (pick_idx),
    .any_valid(pick_any)
  );

  always_comb begin
    state_d       = state_q;
    grant_idx_d   = grant_idx_q;
    last_grant_d  = last_grant_q;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_idx_d = pick_idx;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
          if (grant_idx_q == IDX_W'(i)) begin
            m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            m_axis_tvalid    = s_axis_tvalid[i];
            m_axis_tlast     = s_axis_tlast[i];
            s_axis_tready[i] = m_axis_tready;
            // Grant is released only by an accepted last beat; stalls never time out.
            if (s_axis_tvalid[i] && m_axis_tready && s_axis_tlast[i]) begin
              last_grant_d = grant_idx_q;
              state_d      = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      grant_idx_q  <= '0;
      last_grant_q <= IDX_W'(NUM_PORTS - 1);
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign busy = (state_q == GRANT);

`ifdef AXIS_PKT_ARBITER_TID_EN
  assign m_axis_tid = (state_q == GRANT) ? grant_idx_q : '0;
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Self-checking bench for axis_pkt_arbiter: per-port packet sources, packet-level round-robin model.
module tb_axis_pkt_arbiter;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] s_axis_tdata = '0;
  logic [3:0]  s_axis_tvalid = '0;
  logic [3:0]  s_axis_tlast = '0;
  logic [3:0]  s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;
  logic        busy;
`ifdef AXIS_PKT_ARBITER_TID_EN
  logic [1:0]  m_axis_tid;
`endif

  axis_pkt_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(8)) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .busy         (busy)
`ifdef AXIS_PKT_ARBITER_TID_EN
    ,
    .m_axis_tid   (m_axis_tid)
`endif
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // Source side: queued beats per port; gate[i]=0 hides a port's valid.
  logic [7:0] src_data [4][$];
  bit         src_last [4][$];
  bit         gate [4];
  int         ready_mode = 0;  // 0: always ready, 1: toggle, 2: random
  bit         tog = 1'b1;

  // Model: owner of the output (-1 = free) and last port that finished a packet.
  int owner = -1;
  int last_gnt = 3;
  int pkt_order[$];
  int beats_out [4];
  int tid_log[$];

  task automatic load_pkt(input int p, input int len);
    for (int b = 0; b < len; b++) begin
      src_data[p].push_back(8'($urandom));
      src_last[p].push_back(b == len - 1);
    end
  endtask

  task automatic clear_sources();
    for (int i = 0; i < 4; i++) begin
      src_data[i].delete();
      src_last[i].delete();
      gate[i] = 1'b0;
    end
  endtask

  // One clock cycle: drive sources, check outputs against the model, advance.
  task automatic step();
    logic [3:0] v;
    logic [3:0] exp_ready;
    bit         exp_valid;
    bit         found;
    int         p;
    for (int i = 0; i < 4; i++) begin
      v[i] = gate[i] && (src_data[i].size() != 0);
      s_axis_tdata[i*8 +: 8] = v[i] ? src_data[i][0] : 8'($urandom);
      s_axis_tlast[i]        = v[i] ? src_last[i][0] : 1'($urandom);
    end
    s_axis_tvalid = v;
    case (ready_mode)
      0: m_axis_tready = 1'b1;
      1: begin m_axis_tready = tog; tog = !tog; end
      default: m_axis_tready = 1'($urandom);
    endcase
    #1;
    exp_valid = (owner >= 0) ? v[owner] : 1'b0;
    exp_ready = (owner >= 0 && m_axis_tready) ? 4'(1 << owner) : 4'b0000;
    checks++;
    if (m_axis_tvalid !== exp_valid) begin
      errors++;
      $display("FAIL tvalid t=%0t got %b exp %b", $time, m_axis_tvalid, exp_valid);
    end
    checks++;
    if (s_axis_tready !== exp_ready) begin
      errors++;
      $display("FAIL s_tready t=%0t got %b exp %b", $time, s_axis_tready, exp_ready);
    end
    checks++;
    if (busy !== (owner >= 0)) begin
      errors++;
      $display("FAIL busy t=%0t got %b exp %b", $time, busy, (owner >= 0));
    end
    if (exp_valid) begin
      checks++;
      if (m_axis_tdata !== src_data[owner][0] || m_axis_tlast !== src_last[owner][0]) begin
        errors++;
        $display("FAIL beat t=%0t port %0d got %h/%b exp %h/%b", $time, owner,
                 m_axis_tdata, m_axis_tlast, src_data[owner][0], src_last[owner][0]);
      end
    end
`ifdef AXIS_PKT_ARBITER_TID_EN
    checks++;
    if (m_axis_tid !== ((owner >= 0) ? 2'(owner) : 2'd0)) begin
      errors++;
      $display("FAIL tid t=%0t got %0d exp %0d", $time, m_axis_tid, (owner >= 0) ? owner : 0);
    end
`endif
    if (owner >= 0) begin
      if (v[owner] && m_axis_tready) begin
        beats_out[owner]++;
`ifdef AXIS_PKT_ARBITER_TID_EN
        tid_log.push_back(int'(m_axis_tid));
`endif
        if (src_last[owner][0]) begin
          pkt_order.push_back(owner);
          last_gnt = owner;
          void'(src_data[owner].pop_front());
          void'(src_last[owner].pop_front());
          owner = -1;
        end else begin
          void'(src_data[owner].pop_front());
          void'(src_last[owner].pop_front());
        end
      end
    end else if (v != 4'b0000) begin
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        p = (last_gnt + k) % 4;
        if (!found && v[p]) begin
          owner = p;
          found = 1'b1;
        end
      end
    end
    @(posedge aclk);
    #1;
  endtask

  function automatic bit pending();
    bit r = 1'b0;
    for (int i = 0; i < 4; i++) if (src_data[i].size() != 0) r = 1'b1;
    return r;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while ((pending() || owner >= 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout got %0d cycles exp < %0d", n, budget);
      clear_sources();
    end
    step();
  endtask

  task automatic do_reset();
    clear_sources();
    s_axis_tvalid = '0;
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    owner = -1;
    last_gnt = 3;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b r=%b b=%b exp 0/0000/0", m_axis_tvalid, s_axis_tready, busy);
    end
    ready_mode = 0;
    repeat (10) step();
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    pkt_order.delete();
    ready_mode = 0;
    for (int i = 0; i < 4; i++) begin
      load_pkt(i, 3);
      gate[i] = 1'b1;
    end
    load_pkt(0, 3);
    drain(200);
    checks++;
    if (pkt_order.size() != 5) begin
      errors++;
      $display("FAIL rr_count got %0d exp 5", pkt_order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (pkt_order[i] != exp_order[i]) begin
          errors++;
          $display("FAIL rr_order[%0d] got %0d exp %0d", i, pkt_order[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_late_request();
    int base2;
    int n = 0;
    pkt_order.delete();
    ready_mode = 0;
    load_pkt(2, 5);
    load_pkt(1, 3);
    gate[2] = 1'b1;
    gate[1] = 1'b0;
    base2 = beats_out[2];
    while (beats_out[2] - base2 < 2 && n < 50) begin
      step();
      n++;
    end
    gate[1] = 1'b1;
    drain(100);
    checks++;
    if (pkt_order.size() != 2 || pkt_order[0] != 2 || pkt_order[1] != 1) begin
      errors++;
      $display("FAIL late_order got size %0d first %0d exp 2 then 1", pkt_order.size(),
               (pkt_order.size() != 0) ? pkt_order[0] : -1);
    end
  endtask

  task automatic test_backpressure();
    int base3;
    pkt_order.delete();
    ready_mode = 1;
    tog = 1'b1;
    base3 = beats_out[3];
    load_pkt(3, 4);
    gate[3] = 1'b1;
    drain(100);
    checks++;
    if (beats_out[3] - base3 != 4) begin
      errors++;
      $display("FAIL bp_beats got %0d exp 4", beats_out[3] - base3);
    end
    checks++;
    if (pkt_order.size() != 1) begin
      errors++;
      $display("FAIL bp_tlast_count got %0d exp 1", pkt_order.size());
    end
    ready_mode = 0;
  endtask

  task automatic test_reset_mid();
    int base2;
    int n = 0;
    ready_mode = 0;
    load_pkt(2, 4);
    gate[2] = 1'b1;
    base2 = beats_out[2];
    while (beats_out[2] - base2 < 2 && n < 50) begin
      step();
      n++;
    end
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || s_axis_tready !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset got v=%b b=%b r=%b exp 0/0/0000", m_axis_tvalid, busy, s_axis_tready);
    end
    clear_sources();
    owner = -1;
    last_gnt = 3;
    pkt_order.delete();
    load_pkt(0, 2);
    load_pkt(3, 2);
    gate[0] = 1'b1;
    gate[3] = 1'b1;
    drain(100);
    checks++;
    if (pkt_order.size() != 2 || pkt_order[0] != 0 || pkt_order[1] != 3) begin
      errors++;
      $display("FAIL post_reset_order got size %0d first %0d exp 0 then 3", pkt_order.size(),
               (pkt_order.size() != 0) ? pkt_order[0] : -1);
    end
  endtask

  task automatic test_random();
    int loaded [4];
    int base [4];
    for (int i = 0; i < 4; i++) begin
      loaded[i] = 0;
      base[i] = beats_out[i];
    end
    ready_mode = 2;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (src_data[i].size() == 0 && ($urandom % 4) == 0) begin
          int len = 1 + int'($urandom % 4);
          load_pkt(i, len);
          loaded[i] += len;
        end
        gate[i] = ($urandom % 4) != 0;
      end
      step();
    end
    for (int i = 0; i < 4; i++) gate[i] = 1'b1;
    drain(400);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (beats_out[i] - base[i] != loaded[i]) begin
        errors++;
        $display("FAIL rand_beats port %0d got %0d exp %0d", i, beats_out[i] - base[i], loaded[i]);
      end
    end
    ready_mode = 0;
  endtask

`ifdef AXIS_PKT_ARBITER_TID_EN
  task automatic test_tid();
    do_reset();
    tid_log.delete();
    load_pkt(1, 1);
    load_pkt(3, 1);
    gate[1] = 1'b1;
    gate[3] = 1'b1;
    drain(50);
    checks++;
    if (tid_log.size() != 2 || tid_log[0] != 1 || tid_log[1] != 3) begin
      errors++;
      $display("FAIL tid_seq got size %0d first %0d exp 1 then 3", tid_log.size(),
               (tid_log.size() != 0) ? tid_log[0] : -1);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) begin
      beats_out[i] = 0;
      gate[i] = 1'b0;
    end
    @(posedge aclk);
    #1;
    test_reset();
    test_round_robin();
    test_late_request();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef AXIS_PKT_ARBITER_TID_EN
    test_tid();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_pkt_arbiter.md
AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of AXI-Stream slave requesters (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, tdata width per port.
REQ-003 SHALL have port aclk, input, 1, clock; all logic on rising edge.
REQ-004 SHALL have port areset, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port s_axis_tdata, input, NUM_PORTS*DATA_WIDTH, port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 SHALL have ports s_axis_tvalid / s_axis_tlast, input, NUM_PORTS each, per-port valid / last.
REQ-007 SHALL have port s_axis_tready, output, NUM_PORTS, per-port ready.
REQ-008 SHALL have ports m_axis_tdata (output, DATA_WIDTH), m_axis_tvalid (output, 1), m_axis_tlast (output, 1), m_axis_tready (input, 1), merged stream toward the shared FIFO.
REQ-009 SHALL have port busy, output, 1, high while a packet is granted.

Function
REQ-010 SHALL use a two-state FSM: IDLE, GRANT.
REQ-011 IDLE: m_axis_tvalid=0, all s_axis_tready=0; if any s_axis_tvalid is high, SHALL pick a winner round-robin starting at (last_grant+1) mod NUM_PORTS, register it in grant_idx, go to GRANT next cycle.
REQ-012 Arbitration latency SHALL be exactly 1 cycle from a valid seen in IDLE to m_axis_tvalid possibly high.
REQ-013 GRANT: m_axis_tdata/tvalid/tlast SHALL combinationally equal port grant_idx; s_axis_tready[grant_idx]=m_axis_tready; all other s_axis_tready=0.
REQ-014 Grant SHALL hold for a whole packet; no switch until a beat with tvalid&tready&tlast on the granted port.
REQ-015 On that last beat SHALL set last_grant<=grant_idx and return to IDLE; one idle bubble between packets is required.
REQ-016 Granted port deasserting tvalid mid-packet SHALL keep the grant (no timeout).
REQ-017 Round-robin pointer wrap: after port NUM_PORTS-1 SHALL search from port 0.
REQ-018 Single-beat packet (tlast on first beat) SHALL be granted and released like any other.
REQ-019 busy SHALL equal (state==GRANT).

Reset
REQ-020 On areset SHALL set state=IDLE, grant_idx=0, last_grant=NUM_PORTS-1 (port 0 highest priority first), so m_axis_tvalid=0, s_axis_tready=0, busy=0 in the cycle after.
REQ-021 areset mid-packet SHALL abort the packet without emitting tlast; no recovery of partial data.

Configuration
REQ-022 Macro AXIS_PKT_ARBITER_TID_EN SHALL, when defined, add output m_axis_tid, width $clog2(NUM_PORTS), equal to grant_idx while in GRANT, 0 in IDLE/reset.
REQ-023 Without AXIS_PKT_ARBITER_TID_EN the m_axis_tid port and its logic SHALL not exist; all other behaviour identical.

Structure
REQ-024 Package axis_arb_pkg SHALL hold the FSM state enum (IDLE, GRANT) and a function computing the next round-robin winner from a request vector and last_grant.
REQ-025 Sub-module axis_rr_picker (combinational, request vector + pointer -> winner index + any-valid) SHALL be used for the arbitration decision.

Verification
REQ-026 Reset release, all tvalid=0 -> m_axis_tvalid=0, s_axis_tready=4'b0000, busy=0 for 10 cycles.
REQ-027 Ports 0..3 all valid, 3-beat packets, m_axis_tready=1 -> output packet order 0,1,2,3,0; each beat data correct; 1 idle cycle between packets.
REQ-028 Port 2 sends 5-beat packet, port 1 raises tvalid at beat 2 -> port 1 not granted until cycle after port 2 tlast accepted.
REQ-029 m_axis_tready toggled 1/0 every cycle during 4-beat packet from port 3 -> s_axis_tready[3] mirrors it, no beat lost or duplicated, tlast on 4th beat only.
REQ-030 areset asserted on beat 2 of a 4-beat packet -> next cycle m_axis_tvalid=0, busy=0; post-reset, ports 0 and 3 valid -> port 0 wins.
REQ-031 With AXIS_PKT_ARBITER_TID_EN, single-beat packets on ports 1 and 3 -> m_axis_tid=1 then 3, aligned with tvalid.
